// File: rtl/instr_encoder_loader.sv
// Packs RV32I instruction fields into 32-bit words and writes them sequentially into imem.
// Latency: 1 cycle from accepted bundle to mem_we/mem_addr/mem_wdata.
// Backpressure: in_ready only in LOAD with room left; FULL stalls the producer, never overwrites.
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       finish,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // opCode_t values
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LTYPE = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STYPE = 7'b0100011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JTYPE = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state;
  logic            xfer;
  logic            enc_legal;
  logic [31:0]     enc_word;
  logic [CW-1:0]   count_nxt;
  logic            full_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  // Producer may hand over a bundle only while loading with space remaining
  assign in_ready = (state == ST_LOAD) && (count < CW'(DEPTH));
  assign xfer     = in_valid && in_ready;

  // Field packing per format; imm bits outside the format (and imm[0] of B/J) are dropped
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = 32'd0;
    case (opcode)
      OP_RTYPE:
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_ITYPE, OP_LTYPE, OP_JALR:
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      OP_STYPE:
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OP_BTYPE:
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OP_LUI, OP_AUIPC:
        enc_word = {imm[31:12], rd, opcode};
      OP_JTYPE:
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:
        enc_legal = 1'b0;
    endcase
  end

  // Post-transfer count and whether that fills memory; address uses pre-increment count
  always_comb begin
    count_nxt = (xfer && enc_legal) ? count + CW'(1) : count;
    full_nxt  = (count_nxt == CW'(DEPTH));
    addr_nxt  = ADDR_W'(BASE_ADDR) + (ADDR_W'(count) << 2);
  end

  // Load FSM with registered status outputs and single-cycle write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= 32'd0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        // start wins over finish and over any bundle offered in the same cycle
        state    <= ST_LOAD;
        count    <= '0;
        err      <= 1'b0;
        mem_addr <= ADDR_W'(BASE_ADDR);
        busy     <= 1'b1;
        done     <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (xfer) begin
              if (enc_legal) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr_nxt;
                mem_wdata <= enc_word;
                count     <= count_nxt;
              end else begin
                err <= 1'b1;
              end
            end
            if (finish) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (full_nxt) begin
              state <= ST_FULL;
              busy  <= 1'b0;
            end
          end
          ST_FULL: begin
            if (finish) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4, BASE_ADDR=0).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Expected encodings are hand-computed RV32I words.
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start, finish, in_valid, in_ready;
  logic [6:0]    opcode, funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [31:0]   imm;
  logic          mem_we;
  logic [31:0]   mem_addr, mem_wdata;
  logic [CW-1:0] count;
  logic          busy, done, err;

  int total = 0;
  int bad   = 0;

  instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(0), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  // Presents one bundle for a single edge; in_valid stays high for back-to-back use
  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, mem_we},   32'd0);
    chk({tag, "_addr"},  mem_addr,          32'd0);
    chk({tag, "_wdata"}, mem_wdata,         32'd0);
    chk({tag, "_count"}, 32'(count),        32'd0);
    chk({tag, "_flags"}, {28'd0, busy, done, err, in_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    tick(); tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick();
    chk("idle_rdy", {31'd0, in_ready}, 32'd0);

    // addi x1,x0,5
    do_start();
    chk("start_busy", {30'd0, busy, in_ready}, 32'd3);
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b0;
    chk("addi_we",    {31'd0, mem_we}, 32'd1);
    chk("addi_addr",  mem_addr,        32'd0);
    chk("addi_wdata", mem_wdata,       32'h0050_0093);
    tick();
    chk("addi_we_off", {31'd0, mem_we}, 32'd0);
    do_finish();
    chk("addi_done", {30'd0, done, busy}, 32'd2);

    // sw x2,8(x1) then beq x1,x2,-4
    do_start();
    chk("restart_cnt", {31'd0, done, 30'(count)} & 32'hFFFF_FFFF, 32'd0);
    drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    chk("sw_addr",  mem_addr,  32'd0);
    chk("sw_wdata", mem_wdata, 32'h0020_A423);
    drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC);
    in_valid = 1'b0;
    chk("beq_we",    {31'd0, mem_we}, 32'd1);
    chk("beq_addr",  mem_addr,        32'd4);
    chk("beq_wdata", mem_wdata,       32'hFE20_8EE3);
    chk("beq_count", 32'(count),      32'd2);

    // lui x5,0x12345 ; jal x1,+8
    do_start();
    drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    chk("lui_wdata", mem_wdata, 32'h1234_52B7);
    drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    in_valid = 1'b0;
    chk("jal_wdata", mem_wdata, 32'h0080_00EF);
    chk("jal_addr",  mem_addr,  32'd4);

    // add x3,x1,x2 with funct7 = 0x20 (sub)
    do_start();
    drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    in_valid = 1'b0;
    chk("sub_wdata", mem_wdata, 32'h4020_81B3);

    // illegal opcode sandwiched between two legal bundles
    do_start();
    chk("err_clr", {31'd0, err}, 32'd0);
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    drive(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("ill_we",  {31'd0, mem_we}, 32'd0);
    chk("ill_err", {31'd0, err},    32'd1);
    chk("ill_cnt", 32'(count),      32'd1);
    drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    in_valid = 1'b0;
    chk("ill_next_we",    {31'd0, mem_we}, 32'd1);
    chk("ill_next_addr",  mem_addr,        32'd4);
    chk("ill_next_wdata", mem_wdata,       32'h0070_0113);
    chk("ill_err_sticky", {31'd0, err},    32'd1);

    // fill to DEPTH with six offered bundles; the last two must stall
    do_start();
    for (int i = 0; i < 6; i++) begin
      opcode = 7'b0010011; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
      funct3 = 3'd0; funct7 = 7'd0; imm = 32'(i + 1);
      in_valid = 1'b1;
      chk($sformatf("full_rdy%0d", i), {31'd0, in_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("full_we%0d", i), {31'd0, mem_we}, (i < DEPTH) ? 32'd1 : 32'd0);
      if (i < DEPTH) begin
        chk($sformatf("full_addr%0d", i),  mem_addr,  32'(4 * i));
        chk($sformatf("full_wdata%0d", i), mem_wdata, (32'(i + 1) << 20) | 32'h93);
      end
    end
    in_valid = 1'b0;
    chk("full_count", 32'(count),      32'd4);
    chk("full_busy",  {31'd0, busy},   32'd0);
    chk("full_addr_hold", mem_addr,    32'd12);
    do_finish();
    chk("full_done", {31'd0, done}, 32'd1);

    // reset right after a transfer edge abandons the word
    do_start();
    drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_quiet%0d", i), {30'd0, mem_we, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
